// File: rtl/rv_decode_stage_if.sv
// ---------------------------------------------------------------------------
// rv_decode_stage_if
// Bundles the ID-stage signals: the fetched instruction and its PCs, the
// write-back port into the register file, and everything the decode stage
// produces (operands, immediate, register fields, control).
//   master : fetch/WB side; drives instr, PCs and the WB port, sees results
//   slave  : rv_decode_stage
// ---------------------------------------------------------------------------
interface rv_decode_stage_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] pc_plus_4_in;
    logic            RegWriteW;
    logic [4:0]      rdW;
    logic [XLEN-1:0] resultW;

    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] imm_ext;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            RegWrite;
    logic            MemRead;
    logic            MemWrite;
    logic            ALUSrc;
    logic            Branch;
    logic            Jump;
    logic [1:0]      ALUOp;
    logic [1:0]      ResultSrc;

    modport master (
        output instr, pc_in, pc_plus_4_in, RegWriteW, rdW, resultW,
        input  rdata1, rdata2, imm_ext, rs1_addr, rs2_addr, rd_addr,
               opcode, funct3, funct7, RegWrite, MemRead, MemWrite,
               ALUSrc, Branch, Jump, ALUOp, ResultSrc
    );

    modport slave (
        input  instr, pc_in, pc_plus_4_in, RegWriteW, rdW, resultW,
        output rdata1, rdata2, imm_ext, rs1_addr, rs2_addr, rd_addr,
               opcode, funct3, funct7, RegWrite, MemRead, MemWrite,
               ALUSrc, Branch, Jump, ALUOp, ResultSrc
    );
endinterface

// File: rtl/rv_decode_stage.sv
// ---------------------------------------------------------------------------
// rv_decode_stage
// RV32I instruction-decode stage: field split, immediate generation, main
// control decode and the 32x32 integer register file written by WB.
// All outputs are combinational; the only state is the register file.
//
// Ports:
//   clk    : pipeline clock, register file writes on the rising edge
//   reset  : asynchronous active-high; clears the register file, blocks
//            writes and forces rdata1/rdata2 to zero while asserted
//   dif    : rv_decode_stage_if.slave (instr/PCs/WB port in, decode out)
//
// Build option:
//   WB_BYPASS_EN : when defined, a WB write in the current cycle is forwarded
//                  onto rdata1/rdata2 (write-through). When undefined, reads
//                  return only stored values and hazards belong to the stall
//                  unit.
// ---------------------------------------------------------------------------
module rv_decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic               clk,
    input  logic               reset,
    rv_decode_stage_if.slave   dif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [XLEN-1:0] instr;
    logic [6:0]      opcode;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;

    // PCs travel alongside instr but are consumed in later stages.
    logic unused_pc;
    assign unused_pc = ^{dif.pc_in, dif.pc_plus_4_in};

    assign instr    = dif.instr;
    assign opcode   = instr[6:0];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    // Raw slices for every opcode; consumers ignore fields they don't need.
    assign dif.opcode   = opcode;
    assign dif.rd_addr  = instr[11:7];
    assign dif.funct3   = instr[14:12];
    assign dif.funct7   = instr[31:25];
    assign dif.rs1_addr = rs1_addr;
    assign dif.rs2_addr = rs2_addr;

    // ------------------------------------------------------------------
    // Register file. Entry 0 is never written, so it stays at its reset
    // value; reads of x0 are also masked explicitly below.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_en;

    assign wr_en = dif.RegWriteW && (dif.rdW != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[dif.rdW] <= dif.resultW;
        end
    end

    logic [XLEN-1:0] rdata1_d;
    logic [XLEN-1:0] rdata2_d;

    always_comb begin
        rdata1_d = (rs1_addr == 5'd0) ? '0 : regs_q[rs1_addr];
        rdata2_d = (rs2_addr == 5'd0) ? '0 : regs_q[rs2_addr];
`ifdef WB_BYPASS_EN
        // wr_en already excludes x0, so a zero source is never forwarded.
        if (wr_en && (dif.rdW == rs1_addr)) rdata1_d = dif.resultW;
        if (wr_en && (dif.rdW == rs2_addr)) rdata2_d = dif.resultW;
`endif
        // Reset gates the forwarded path too, not just the stored values.
        if (reset) begin
            rdata1_d = '0;
            rdata2_d = '0;
        end
    end

    assign dif.rdata1 = rdata1_d;
    assign dif.rdata2 = rdata2_d;

    // ------------------------------------------------------------------
    // Immediate generation
    // ------------------------------------------------------------------
    logic [XLEN-1:0] imm_d;

    always_comb begin
        imm_d = '0;
        case (opcode)
            OP_LOAD, OP_I_ALU, OP_JALR:
                imm_d = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm_d = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm_d = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm_d = {instr[31:12], 12'b0};
            OP_JAL:
                imm_d = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
            default:
                imm_d = '0;
        endcase
    end

    assign dif.imm_ext = imm_d;

    // ------------------------------------------------------------------
    // Main control. Unknown opcodes decode to all-zero, i.e. a bubble.
    // JAL/JALR assert RegWrite even for rd=x0; the register file drops it.
    // ------------------------------------------------------------------
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
    logic [1:0] result_src;

    always_comb begin
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_op     = 2'b00;
        result_src = 2'b00;
        case (opcode)
            OP_R: begin
                reg_write = 1'b1;
                alu_op    = 2'b10;
            end
            OP_I_ALU: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = 2'b10;
            end
            OP_LOAD: begin
                reg_write  = 1'b1;
                mem_read   = 1'b1;
                alu_src    = 1'b1;
                result_src = 2'b01;
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
            end
            OP_BRANCH: begin
                branch = 1'b1;
                alu_op = 2'b01;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                result_src = 2'b10;
            end
            OP_JALR: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                jump       = 1'b1;
                result_src = 2'b10;
            end
            OP_LUI: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = 2'b11;
            end
            OP_AUIPC: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            default: begin
                reg_write = 1'b0;
            end
        endcase
    end

    assign dif.RegWrite  = reg_write;
    assign dif.MemRead   = mem_read;
    assign dif.MemWrite  = mem_write;
    assign dif.ALUSrc    = alu_src;
    assign dif.Branch    = branch;
    assign dif.Jump      = jump;
    assign dif.ALUOp     = alu_op;
    assign dif.ResultSrc = result_src;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench for rv_decode_stage. Expected results are queued when
// stimulus is applied and popped when the combinational outputs are sampled.
module tb_rv_decode_stage;

    logic clk;
    logic reset;

    rv_decode_stage_if #(.XLEN(32)) dif ();

    rv_decode_stage #(.XLEN(32), .NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .dif   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // ctrl packing: {RegWrite,MemRead,MemWrite,ALUSrc,Branch,Jump,ALUOp,ResultSrc}
    localparam logic [9:0] C_R     = 10'b1000001000;
    localparam logic [9:0] C_IALU  = 10'b1001001000;
    localparam logic [9:0] C_LOAD  = 10'b1101000001;
    localparam logic [9:0] C_STORE = 10'b0011000000;
    localparam logic [9:0] C_BR    = 10'b0000100100;
    localparam logic [9:0] C_JAL   = 10'b1000010010;
    localparam logic [9:0] C_JALR  = 10'b1001010010;
    localparam logic [9:0] C_LUI   = 10'b1001000011;
    localparam logic [9:0] C_AUIPC = 10'b1001000000;
    localparam logic [9:0] C_NOP   = 10'b0000000000;

    typedef struct {
        string       name;
        bit          chk_dec;
        logic [31:0] imm;
        logic [9:0]  ctrl;
        logic [4:0]  rd;
        bit          chk_src;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        bit          chk_rf;
        logic [31:0] rd1;
        logic [31:0] rd2;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [9:0]  ctrl;
        logic [4:0]  rd;
    } vec_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic [31:0] ins, input logic we,
                         input logic [4:0] rdw, input logic [31:0] res);
        dif.instr        = ins;
        dif.pc_in        = 32'h0000_1000;
        dif.pc_plus_4_in = 32'h0000_1004;
        dif.RegWriteW    = we;
        dif.rdW          = rdw;
        dif.resultW      = res;
    endtask

    task automatic sample_and_check();
        exp_t e;
        logic [9:0] ctrl;
        #2;
        if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard: queue empty");
            return;
        end
        e = sb_q.pop_front();
        ctrl = {dif.RegWrite, dif.MemRead, dif.MemWrite, dif.ALUSrc, dif.Branch,
                dif.Jump, dif.ALUOp, dif.ResultSrc};
        if (e.chk_dec) begin
            chk({e.name, ".imm"},  dif.imm_ext, e.imm);
            chk({e.name, ".ctrl"}, {22'd0, ctrl}, {22'd0, e.ctrl});
            chk({e.name, ".rd"},   {27'd0, dif.rd_addr}, {27'd0, e.rd});
        end
        if (e.chk_src) begin
            chk({e.name, ".rs1"},    {27'd0, dif.rs1_addr}, {27'd0, e.rs1});
            chk({e.name, ".rs2"},    {27'd0, dif.rs2_addr}, {27'd0, e.rs2});
            chk({e.name, ".funct7"}, {25'd0, dif.funct7},   {25'd0, e.f7});
        end
        if (e.chk_rf) begin
            chk({e.name, ".rdata1"}, dif.rdata1, e.rd1);
            chk({e.name, ".rdata2"}, dif.rdata2, e.rd2);
        end
    endtask

    function automatic exp_t mk_rf(input string nm, input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        e = '{name: nm, chk_dec: 1'b0, imm: '0, ctrl: '0, rd: '0, chk_src: 1'b0,
              rs1: '0, rs2: '0, f7: '0, chk_rf: 1'b1, rd1: r1, rd2: r2};
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[15];
    exp_t e;

    initial begin
        vecs[0]  = '{"addi20",   32'h01400613, 32'd20,        C_IALU,  5'd12};
        vecs[1]  = '{"addi_min", 32'h80000093, 32'hFFFFF800,  C_IALU,  5'd1};
        vecs[2]  = '{"lw_neg",   32'hFFC12283, 32'hFFFFFFFC,  C_LOAD,  5'd5};
        vecs[3]  = '{"sw8",      32'h00612423, 32'd8,         C_STORE, 5'd8};
        vecs[4]  = '{"sw_m1",    32'hFE000FA3, 32'hFFFFFFFF,  C_STORE, 5'd31};
        vecs[5]  = '{"beq_m8",   32'hFE208CE3, 32'hFFFFFFF8,  C_BR,    5'd25};
        vecs[6]  = '{"beq16",    32'h00208863, 32'd16,        C_BR,    5'd16};
        vecs[7]  = '{"jal64",    32'h0400006F, 32'd64,        C_JAL,   5'd0};
        vecs[8]  = '{"jal_m4",   32'hFFDFF0EF, 32'hFFFFFFFC,  C_JAL,   5'd1};
        vecs[9]  = '{"jalr",     32'h000280E7, 32'd0,         C_JALR,  5'd1};
        vecs[10] = '{"lui",      32'h123452B7, 32'h12345000,  C_LUI,   5'd5};
        vecs[11] = '{"auipc",    32'hFFFFF297, 32'hFFFFF000,  C_AUIPC, 5'd5};
        vecs[12] = '{"add",      32'h00B585B3, 32'd0,         C_R,     5'd11};
        vecs[13] = '{"fence",    32'h0000000F, 32'd0,         C_NOP,   5'd0};
        vecs[14] = '{"ones",     32'hFFFFFFFF, 32'd0,         C_NOP,   5'd31};

        // Reset phase: WB write to x3 must be blocked and rdata forced to 0,
        // while decode stays valid.
        reset = 1'b1;
        drive(32'h003181B3, 1'b1, 5'd3, 32'h0000DEAD);
        #1;
        e = mk_rf("in_reset", 32'd0, 32'd0);
        e.chk_dec = 1'b1; e.imm = 32'd0; e.ctrl = C_R; e.rd = 5'd3;
        sb_q.push_back(e);
        sample_and_check();
        #7;
        reset = 1'b0;
        #1;
        drive(32'h003181B3, 1'b0, 5'd0, 32'd0);
        sb_q.push_back(mk_rf("x3_after_reset", 32'd0, 32'd0));
        sample_and_check();
        step();

        // Decode table
        foreach (vecs[i]) begin
            drive(vecs[i].instr, 1'b0, 5'd0, 32'd0);
            e = '{name: vecs[i].name, chk_dec: 1'b1, imm: vecs[i].imm,
                  ctrl: vecs[i].ctrl, rd: vecs[i].rd, chk_src: 1'b0, rs1: '0,
                  rs2: '0, f7: '0, chk_rf: 1'b0, rd1: '0, rd2: '0};
            sb_q.push_back(e);
            sample_and_check();
            step();
        end

        // ADDI x12,x0,20
        drive(32'h01400613, 1'b0, 5'd0, 32'd0);
        e = mk_rf("tp_addi20", 32'd0, 32'd0);
        e.chk_dec = 1'b1; e.imm = 32'd20; e.ctrl = C_IALU; e.rd = 5'd12;
        sb_q.push_back(e);
        sample_and_check();
        step();

        // ADDI x11,x0,4 while WB writes x12=50
        drive(32'h00400593, 1'b1, 5'd12, 32'd50);
        e = mk_rf("tp_addi4", 32'd0, 32'd0);
        e.chk_dec = 1'b1; e.imm = 32'd4; e.ctrl = C_IALU; e.rd = 5'd11;
        sb_q.push_back(e);
        sample_and_check();
        step();

        // ADD x11,x11,x11 while WB writes x11=10
        drive(32'h00B585B3, 1'b1, 5'd11, 32'd10);
        e = mk_rf("tp_add_same", BYP ? 32'd10 : 32'd0, BYP ? 32'd10 : 32'd0);
        e.chk_src = 1'b1; e.rs1 = 5'd11; e.rs2 = 5'd11; e.f7 = 7'd0;
        e.chk_dec = 1'b1; e.imm = 32'd0; e.ctrl = C_R; e.rd = 5'd11;
        sb_q.push_back(e);
        sample_and_check();
        step();

        // ADD x12,x11,x12 while WB writes x11=20
        drive(32'h00C58633, 1'b1, 5'd11, 32'd20);
        sb_q.push_back(mk_rf("tp_add_mix", BYP ? 32'd20 : 32'd10, 32'd50));
        sample_and_check();
        step();

        // JAL x0,64
        drive(32'h0400006F, 1'b0, 5'd0, 32'd0);
        e = mk_rf("tp_jal", 32'd0, 32'd0);
        e.chk_dec = 1'b1; e.imm = 32'd64; e.ctrl = C_JAL; e.rd = 5'd0;
        e.chk_src = 1'b1; e.rs1 = 5'd0; e.rs2 = 5'd0; e.f7 = 7'd2;
        sb_q.push_back(e);
        sample_and_check();
        step();

        // Write to x0 is neither forwarded nor stored
        drive(32'h00000033, 1'b1, 5'd0, 32'hFFFFFFFF);
        sb_q.push_back(mk_rf("x0_write", 32'd0, 32'd0));
        sample_and_check();
        step();
        drive(32'h00000033, 1'b0, 5'd0, 32'd0);
        sb_q.push_back(mk_rf("x0_after", 32'd0, 32'd0));
        sample_and_check();
        step();

        // WB to a register neither source names: stored values only
        drive(32'h00C58633, 1'b1, 5'd13, 32'h00000777);
        sb_q.push_back(mk_rf("no_match", 32'd20, 32'd50));
        sample_and_check();
        step();
        drive(32'h000680B3, 1'b0, 5'd0, 32'd0);
        sb_q.push_back(mk_rf("x13_stored", 32'h00000777, 32'd0));
        sample_and_check();

        // Mid-cycle reset with a pending WB write
        reset = 1'b1;
        drive(32'h00C58633, 1'b1, 5'd11, 32'h00000055);
        sb_q.push_back(mk_rf("mid_reset", 32'd0, 32'd0));
        sample_and_check();
        step();
        #2;
        reset = 1'b0;
        drive(32'h00C58633, 1'b0, 5'd0, 32'd0);
        sb_q.push_back(mk_rf("post_reset_x11_x12", 32'd0, 32'd0));
        sample_and_check();
        drive(32'h000680B3, 1'b0, 5'd0, 32'd0);
        sb_q.push_back(mk_rf("post_reset_x13", 32'd0, 32'd0));
        sample_and_check();
        step();

        // First qualified write after reset
        drive(32'h00B585B3, 1'b1, 5'd11, 32'h00000099);
        sb_q.push_back(mk_rf("first_write", BYP ? 32'h99 : 32'd0, BYP ? 32'h99 : 32'd0));
        sample_and_check();
        step();
        drive(32'h00B585B3, 1'b0, 5'd0, 32'd0);
        sb_q.push_back(mk_rf("first_write_stored", 32'h99, 32'h99));
        sample_and_check();

        if (sb_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish before 20000");
        $fatal(1);
    end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Instruction-decode (ID) stage of the 5-stage RV32I pipeline.
- Splits the fetched instruction into its fields and generates the sign-extended immediate and the main control signals.
- Holds the 32x32 integer register file, which the write-back (WB) stage writes.
- Read ports include a write-through bypass, so a value being written back in the same cycle is visible immediately.

Parameters:
- XLEN, 32, data/register width (fixed at 32 for RV32I).
- NREGS, 32, number of architectural registers; x0 is hard-wired to zero.

Ports:
- clk  in  1  pipeline clock; register file writes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr  in  32  instruction in ID.
- pc_in  in  32  PC of instr; not consumed by this block.
- pc_plus_4_in  in  32  PC+4 of instr; not consumed by this block.
- RegWriteW  in  1  WB write enable.
- rdW  in  5  WB destination register.
- resultW  in  32  WB write data.
- rdata1  out  32  value of register rs1, after bypass.
- rdata2  out  32  value of register rs2, after bypass.
- imm_ext  out  32  sign-extended immediate.
- rs1_addr, rs2_addr, rd_addr  out  5 each  instr[19:15], instr[24:20], instr[11:7].
- opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  7  instr[31:25].
- RegWrite, MemRead, MemWrite, ALUSrc, Branch, Jump  out  1 each  control signals.
- ALUOp  out  2  00 = add, 01 = branch compare, 10 = decode from funct fields.
- ResultSrc  out  2  00 = ALU, 01 = memory, 10 = PC+4, 11 = immediate.

Behaviour:
- All outputs are combinational from instr and the register-file state; no pipeline register is inside this block.
- Field outputs are the raw bit slices of instr for every opcode; they are not masked.
- Register file:
  - Write on posedge clk when RegWriteW=1 and rdW!=0.
  - Writes to x0 are ignored; x0 always reads 0.
  - reset asynchronously clears all 32 registers. While reset=1, writes are blocked and both rdata outputs are 0.
- Bypass (see Optional Feature): rdataN = resultW when RegWriteW=1, rdW==rsN_addr and rsN_addr!=0. Otherwise rdataN is the stored value.
- When both ports name the same register, both are bypassed identically.
- Immediate generation, by opcode:
  - I-type (0000011, 0010011, 1100111): sext(instr[31:20]).
  - S-type (0100011): sext({instr[31:25], instr[11:7]}).
  - B-type (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - All other opcodes: 0.
- Control, listed as RegWrite, MemRead, MemWrite, ALUSrc, Branch, Jump, ALUOp, ResultSrc:
  - R 0110011: 1,0,0,0,0,0,10,00.
  - I-ALU 0010011: 1,0,0,1,0,0,10,00.
  - Load 0000011: 1,1,0,1,0,0,00,01.
  - Store 0100011: 0,0,1,1,0,0,00,00.
  - Branch 1100011: 0,0,0,0,1,0,01,00.
  - JAL 1101111: 1,0,0,0,0,1,00,10.
  - JALR 1100111: 1,0,0,1,0,1,00,10.
  - LUI 0110111: 1,0,0,1,0,0,00,11.
  - AUIPC 0010111: 1,0,0,1,0,0,00,00.
  - Any other opcode: all zeros (acts as a NOP bubble).
- RegWrite=1 for JAL/JALR even when rd=x0; the x0 write is discarded downstream.
- Control and immediate outputs depend only on instr and are valid during reset.
- Reset deasserted mid-cycle: the register file stays zero until the first qualified write edge.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: write-through bypass as described in Behaviour. Same-cycle WB data appears on rdata1/rdata2.
- Undefined: rdata returns only the stored value; a WB write is visible only after the clock edge. Hazard handling then falls to the stall unit.
- Standard pipeline builds define WB_BYPASS_EN.

Test Plan:
- reset=1 for 10 ns, release, then instr=0x01400613 (ADDI x12,x0,20) with RegWriteW=0 -> rd=12, rs1=0, imm_ext=20, RegWrite=1, ALUSrc=1, ALUOp=10, ResultSrc=00, rdata1=0.
- instr=0x00400593 (ADDI x11,x0,4) with WB RegWriteW=1, rdW=12, resultW=50 across a posedge -> rd=11, imm_ext=4, rdata1=0; x12 now holds 50.
- instr=0x00b585b3 (ADD x11,x11,x11) with RegWriteW=1, rdW=11, resultW=10 -> rs1=rs2=rd=11, funct7=0, ALUSrc=0, rdata1=rdata2=10 (bypass).
- instr=0x00c58633 (ADD x12,x11,x12) with rdW=11, resultW=20 -> rdata1=20 (bypass), rdata2=50 (stored x12).
- instr=0x0400006f (JAL x0,64) with RegWriteW=0 -> imm_ext=64, Jump=1, ResultSrc=10, Branch=0, rs1=rs2=0, rdata1=rdata2=0.
- Write x0 via RegWriteW=1, rdW=0, resultW=0xFFFFFFFF; assert reset mid-run -> reads of x0 always 0; all registers read 0 after reset.
